// File: rtl/axil_slave_bridge.sv
// AXI4-Lite slave front end for register-file handlers.
// Turns AXI4-Lite reads/writes into one-cycle ASHI request pulses, waits for
// the handler to report idle (or for the watchdog to expire), and returns a
// registered response that is held until the master accepts it.
// Write and read paths are two independent FSMs sharing nothing but the clock.
module axil_slave_bridge #(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int ADDR_SPAN = 4096,
    parameter int TIMEOUT   = 256
) (
    input  logic            clk,
    input  logic            resetn,
    // handler side, write
    output logic [AW-1:0]   ASHI_WADDR,
    output logic [DW-1:0]   ASHI_WDATA,
    output logic [DW/8-1:0] ASHI_WSTRB,
    output logic            ASHI_WRITE,
    input  logic            ASHI_WIDLE,
    input  logic [1:0]      ASHI_WRESP,
    // handler side, read
    output logic [AW-1:0]   ASHI_RADDR,
    output logic            ASHI_READ,
    input  logic            ASHI_RIDLE,
    input  logic [DW-1:0]   ASHI_RDATA,
    input  logic [1:0]      ASHI_RRESP,
    // AXI AW channel
    input  logic [AW-1:0]   AXI_AWADDR,
    input  logic            AXI_AWVALID,
    input  logic [2:0]      AXI_AWPROT,
    output logic            AXI_AWREADY,
    // AXI W channel
    input  logic [DW-1:0]   AXI_WDATA,
    input  logic [DW/8-1:0] AXI_WSTRB,
    input  logic            AXI_WVALID,
    output logic            AXI_WREADY,
    // AXI B channel
    output logic [1:0]      AXI_BRESP,
    output logic            AXI_BVALID,
    input  logic            AXI_BREADY,
    // AXI AR channel
    input  logic [AW-1:0]   AXI_ARADDR,
    input  logic            AXI_ARVALID,
    input  logic [2:0]      AXI_ARPROT,
    output logic            AXI_ARREADY,
    // AXI R channel
    output logic [DW-1:0]   AXI_RDATA,
    output logic [1:0]      AXI_RRESP,
    output logic            AXI_RVALID,
    input  logic            AXI_RREADY
);

    localparam int SW = DW / 8;
    // Watchdog counter is wide enough to hold TIMEOUT; keep at least one bit
    // so a disabled watchdog still elaborates.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [AW:0]   SPAN     = (AW + 1)'(ADDR_SPAN);
    localparam bit            WDOG_ON  = (TIMEOUT > 0);

    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] W_ACCEPT = 2'd0;
    localparam logic [1:0] W_CALL   = 2'd1;
    localparam logic [1:0] W_WAIT   = 2'd2;
    localparam logic [1:0] W_RESP   = 2'd3;

    localparam logic [1:0] R_ACCEPT = 2'd0;
    localparam logic [1:0] R_CALL   = 2'd1;
    localparam logic [1:0] R_WAIT   = 2'd2;
    localparam logic [1:0] R_RESP   = 2'd3;

    // Protection bits carry no meaning for the register handlers.
    logic unused_prot;
    assign unused_prot = ^{AXI_AWPROT, AXI_ARPROT};

    // ---------------- write path ----------------
    logic [1:0]    w_state_reg;
    logic          aw_got_reg, w_got_reg;
    logic          awready_reg, wready_reg;
    logic          bvalid_reg;
    logic [1:0]    bresp_reg;
    logic          wcall_reg;
    logic [AW-1:0] waddr_reg;
    logic [DW-1:0] wdata_reg;
    logic [SW-1:0] wstrb_reg;
    logic [CW-1:0] wcnt_reg;

    logic          aw_hs, w_hs, aw_have, w_have, waddr_bad, w_timeout;
    logic [AW-1:0] waddr_cur;

    assign aw_hs     = AXI_AWVALID & awready_reg;
    assign w_hs      = AXI_WVALID & wready_reg;
    assign aw_have   = aw_got_reg | aw_hs;
    assign w_have    = w_got_reg | w_hs;
    // Decode against the address being latched this cycle, not the stale one.
    assign waddr_cur = aw_hs ? AXI_AWADDR : waddr_reg;
    assign waddr_bad = ({1'b0, waddr_cur} >= SPAN);
    assign w_timeout = WDOG_ON && (wcnt_reg == CNT_LAST);

    // Write FSM: join AW and W, pulse the handler, wait, then hold the B response.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            w_state_reg <= W_ACCEPT;
            aw_got_reg  <= 1'b0;
            w_got_reg   <= 1'b0;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= 2'b00;
            wcall_reg   <= 1'b0;
            waddr_reg   <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            wcnt_reg    <= '0;
        end else begin
            wcall_reg <= 1'b0;
            case (w_state_reg)
                W_ACCEPT: begin
                    if (aw_hs) waddr_reg <= AXI_AWADDR;
                    if (w_hs) begin
                        wdata_reg <= AXI_WDATA;
                        wstrb_reg <= AXI_WSTRB;
                    end
                    if (aw_have && w_have) begin
                        aw_got_reg  <= 1'b0;
                        w_got_reg   <= 1'b0;
                        awready_reg <= 1'b0;
                        wready_reg  <= 1'b0;
                        if (waddr_bad) begin
                            bresp_reg   <= RESP_DECERR;
                            bvalid_reg  <= 1'b1;
                            w_state_reg <= W_RESP;
                        end else begin
                            wcall_reg   <= 1'b1;
                            w_state_reg <= W_CALL;
                        end
                    end else begin
                        // Each channel stays ready until its own handshake.
                        aw_got_reg  <= aw_have;
                        w_got_reg   <= w_have;
                        awready_reg <= ~aw_have;
                        wready_reg  <= ~w_have;
                    end
                end
                W_CALL: begin
                    wcnt_reg    <= '0;
                    w_state_reg <= W_WAIT;
                end
                W_WAIT: begin
                    // Handler completion takes priority over the watchdog.
                    if (ASHI_WIDLE) begin
                        bresp_reg   <= ASHI_WRESP;
                        bvalid_reg  <= 1'b1;
                        w_state_reg <= W_RESP;
                    end else if (w_timeout) begin
                        bresp_reg   <= RESP_SLVERR;
                        bvalid_reg  <= 1'b1;
                        w_state_reg <= W_RESP;
                    end else if (wcnt_reg != CNT_MAX) begin
                        wcnt_reg <= wcnt_reg + CW'(1);
                    end
                end
                W_RESP: begin
                    if (AXI_BREADY) begin
                        bvalid_reg  <= 1'b0;
                        awready_reg <= 1'b1;
                        wready_reg  <= 1'b1;
                        w_state_reg <= W_ACCEPT;
                    end
                end
                default: w_state_reg <= W_ACCEPT;
            endcase
        end
    end

    assign ASHI_WADDR  = waddr_reg;
    assign ASHI_WDATA  = wdata_reg;
    assign ASHI_WSTRB  = wstrb_reg;
    assign ASHI_WRITE  = wcall_reg;
    assign AXI_AWREADY = awready_reg;
    assign AXI_WREADY  = wready_reg;
    assign AXI_BVALID  = bvalid_reg;
    assign AXI_BRESP   = bresp_reg;

    // ---------------- read path ----------------
    logic [1:0]    r_state_reg;
    logic          arready_reg;
    logic          rvalid_reg;
    logic [1:0]    rresp_reg;
    logic [DW-1:0] rdata_reg;
    logic          rcall_reg;
    logic [AW-1:0] raddr_reg;
    logic [CW-1:0] rcnt_reg;

    logic ar_hs, raddr_bad, r_timeout;

    assign ar_hs     = AXI_ARVALID & arready_reg;
    assign raddr_bad = ({1'b0, AXI_ARADDR} >= SPAN);
    assign r_timeout = WDOG_ON && (rcnt_reg == CNT_LAST);

    // Read FSM: accept AR, pulse the handler, wait, then hold the R response.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state_reg <= R_ACCEPT;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rresp_reg   <= 2'b00;
            rdata_reg   <= '0;
            rcall_reg   <= 1'b0;
            raddr_reg   <= '0;
            rcnt_reg    <= '0;
        end else begin
            rcall_reg <= 1'b0;
            case (r_state_reg)
                R_ACCEPT: begin
                    if (ar_hs) begin
                        raddr_reg   <= AXI_ARADDR;
                        arready_reg <= 1'b0;
                        if (raddr_bad) begin
                            rresp_reg   <= RESP_DECERR;
                            rdata_reg   <= '0;
                            rvalid_reg  <= 1'b1;
                            r_state_reg <= R_RESP;
                        end else begin
                            rcall_reg   <= 1'b1;
                            r_state_reg <= R_CALL;
                        end
                    end else begin
                        arready_reg <= 1'b1;
                    end
                end
                R_CALL: begin
                    rcnt_reg    <= '0;
                    r_state_reg <= R_WAIT;
                end
                R_WAIT: begin
                    if (ASHI_RIDLE) begin
                        rresp_reg   <= ASHI_RRESP;
                        rdata_reg   <= ASHI_RDATA;
                        rvalid_reg  <= 1'b1;
                        r_state_reg <= R_RESP;
                    end else if (r_timeout) begin
                        rresp_reg   <= RESP_SLVERR;
                        rdata_reg   <= '0;
                        rvalid_reg  <= 1'b1;
                        r_state_reg <= R_RESP;
                    end else if (rcnt_reg != CNT_MAX) begin
                        rcnt_reg <= rcnt_reg + CW'(1);
                    end
                end
                R_RESP: begin
                    if (AXI_RREADY) begin
                        rvalid_reg  <= 1'b0;
                        arready_reg <= 1'b1;
                        r_state_reg <= R_ACCEPT;
                    end
                end
                default: r_state_reg <= R_ACCEPT;
            endcase
        end
    end

    assign ASHI_RADDR  = raddr_reg;
    assign ASHI_READ   = rcall_reg;
    assign AXI_ARREADY = arready_reg;
    assign AXI_RVALID  = rvalid_reg;
    assign AXI_RRESP   = rresp_reg;
    assign AXI_RDATA   = rdata_reg;

endmodule
